quad_corner_tracker: RTL

- Upstream feeder of perspective_params: scans one camera frame of marker-classified pixels and reports the four extreme corners of the projected quad as (x1,y1)..(x4,y4), in the cyclic order perspective_params expects.
- Per-frame running extremes, committed at each frame boundary. perspective_params reads the held corner registers directly.

---
 rtl/quad_pkg.sv | 18 +
 rtl/corner_extreme.sv | 51 +++++
 rtl/quad_corner_tracker.sv | 135 +++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// quad_pkg: shared widths, FSM encoding and tracker init constants for the quad corner tracker.
package quad_pkg;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int SUM_W = 11;
    localparam int CNT_W = 19;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Init keys sit beyond any reachable x+y or x-y so the first marker always wins.
    localparam logic [SUM_W-1:0] S_MAX_INIT = '0;
    localparam logic [SUM_W-1:0] S_MIN_INIT = '1;
    localparam logic [SUM_W-1:0] D_MAX_INIT = {1'b1, {(SUM_W-1){1'b0}}};
    localparam logic [SUM_W-1:0] D_MIN_INIT = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
endpackage

// File: rtl/corner_extreme.sv
// corner_extreme: keeps one running extreme key (max or min, signed or unsigned) and the pixel that set it.
module corner_extreme
    import quad_pkg::*;
#(
    parameter bit               FIND_MAX   = 1'b1,
    parameter bit               SIGNED_KEY = 1'b0,
    parameter logic [SUM_W-1:0] INIT_KEY   = '0
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             init_i,
    input  logic             valid_i,
    input  logic [SUM_W-1:0] key_i,
    input  logic [X_W-1:0]   x_i,
    input  logic [Y_W-1:0]   y_i,
    output logic [X_W-1:0]   x_o,
    output logic [Y_W-1:0]   y_o
);
    logic [SUM_W-1:0] key_q, key_d, base_key;
    logic [X_W-1:0]   x_q, x_d, base_x;
    logic [Y_W-1:0]   y_q, y_d, base_y;
    logic             gt, lt, take;

    // A pixel arriving with init is compared against the fresh init key, so it is never lost.
    always_comb begin
        base_key = init_i ? INIT_KEY : key_q;
        base_x   = init_i ? '0 : x_q;
        base_y   = init_i ? '0 : y_q;
        gt       = SIGNED_KEY ? ($signed(key_i) > $signed(base_key)) : (key_i > base_key);
        lt       = SIGNED_KEY ? ($signed(key_i) < $signed(base_key)) : (key_i < base_key);
        take     = valid_i && (FIND_MAX ? gt : lt);
        key_d    = take ? key_i : base_key;
        x_d      = take ? x_i : base_x;
        y_d      = take ? y_i : base_y;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            key_q <= INIT_KEY;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            key_q <= key_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;
endmodule

// File: rtl/quad_corner_tracker.sv
// quad_corner_tracker: per-frame extreme-corner search over marker pixels, committed at each frame_start.
module quad_corner_tracker
    import quad_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int MIN_PIXELS = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             pixel_valid,
    input  logic [X_W-1:0]   pixel_x,
    input  logic [Y_W-1:0]   pixel_y,
    input  logic             is_marker,
    output logic [X_W-1:0]   x1,
    output logic [X_W-1:0]   x2,
    output logic [X_W-1:0]   x3,
    output logic [X_W-1:0]   x4,
    output logic [Y_W-1:0]   y1,
    output logic [Y_W-1:0]   y2,
    output logic [Y_W-1:0]   y3,
    output logic [Y_W-1:0]   y4,
    output logic             frame_done,
    output logic             quad_found,
    output logic [CNT_W-1:0] marker_count
);
    localparam logic [X_W-1:0]   X_LIM   = X_W'(WIDTH);
    localparam logic [Y_W-1:0]   Y_LIM   = Y_W'(HEIGHT);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIXELS);

    logic             s1_vld_q, s1_tag_q;
    logic [X_W-1:0]   s1_x_q;
    logic [Y_W-1:0]   s1_y_q;
    logic [SUM_W-1:0] s1_s_q, s1_d_q;
    logic             qual;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             tracking, upd, commit, load;
    logic [X_W-1:0]   cx [4];
    logic [Y_W-1:0]   cy [4];
    logic [X_W-1:0]   ox_q [4];
    logic [Y_W-1:0]   oy_q [4];
    logic             done_q, found_q;
    logic [CNT_W-1:0] mcount_q;

    assign qual = pixel_valid && is_marker && (pixel_x < X_LIM) && (pixel_y < Y_LIM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            s1_tag_q <= 1'b0;
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_s_q   <= '0;
            s1_d_q   <= '0;
        end else begin
            s1_vld_q <= qual;
            s1_tag_q <= frame_start;
            s1_x_q   <= pixel_x;
            s1_y_q   <= pixel_y;
            s1_s_q   <= SUM_W'(pixel_x) + SUM_W'(pixel_y);
            s1_d_q   <= SUM_W'(pixel_x) - SUM_W'(pixel_y);
        end
    end

    // The tag in S1 re-initialises the trackers; its own pixel already belongs to the new frame.
    always_comb begin
        tracking = state_q != ST_IDLE;
        upd      = s1_vld_q && (tracking || s1_tag_q);
        commit   = s1_tag_q && tracking;
        load     = commit && (cnt_q >= CNT_MIN);
        state_d  = s1_tag_q ? (tracking ? ST_COMMIT : ST_TRACK)
                            : (state_q == ST_COMMIT ? ST_TRACK : state_q);
        cnt_base = s1_tag_q ? '0 : cnt_q;
        cnt_d    = cnt_base + CNT_W'(upd && (cnt_base != CNT_SAT));
    end

    corner_extreme #(.FIND_MAX(1'b1), .SIGNED_KEY(1'b0), .INIT_KEY(S_MAX_INIT)) u_c1 (
        .clock_i(clock), .reset_n_i(reset_n), .init_i(s1_tag_q), .valid_i(upd),
        .key_i(s1_s_q), .x_i(s1_x_q), .y_i(s1_y_q), .x_o(cx[0]), .y_o(cy[0])
    );
    corner_extreme #(.FIND_MAX(1'b0), .SIGNED_KEY(1'b1), .INIT_KEY(D_MIN_INIT)) u_c2 (
        .clock_i(clock), .reset_n_i(reset_n), .init_i(s1_tag_q), .valid_i(upd),
        .key_i(s1_d_q), .x_i(s1_x_q), .y_i(s1_y_q), .x_o(cx[1]), .y_o(cy[1])
    );
    corner_extreme #(.FIND_MAX(1'b0), .SIGNED_KEY(1'b0), .INIT_KEY(S_MIN_INIT)) u_c3 (
        .clock_i(clock), .reset_n_i(reset_n), .init_i(s1_tag_q), .valid_i(upd),
        .key_i(s1_s_q), .x_i(s1_x_q), .y_i(s1_y_q), .x_o(cx[2]), .y_o(cy[2])
    );
    corner_extreme #(.FIND_MAX(1'b1), .SIGNED_KEY(1'b1), .INIT_KEY(D_MAX_INIT)) u_c4 (
        .clock_i(clock), .reset_n_i(reset_n), .init_i(s1_tag_q), .valid_i(upd),
        .key_i(s1_d_q), .x_i(s1_x_q), .y_i(s1_y_q), .x_o(cx[3]), .y_o(cy[3])
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            mcount_q <= '0;
            for (int i = 0; i < 4; i++) begin
                ox_q[i] <= '0;
                oy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= commit;
            if (commit) begin
                mcount_q <= cnt_q;
                found_q  <= load;
            end
            if (load) begin
                for (int i = 0; i < 4; i++) begin
                    ox_q[i] <= cx[i];
                    oy_q[i] <= cy[i];
                end
            end
        end
    end

    assign x1           = ox_q[0];
    assign x2           = ox_q[1];
    assign x3           = ox_q[2];
    assign x4           = ox_q[3];
    assign y1           = oy_q[0];
    assign y2           = oy_q[1];
    assign y3           = oy_q[2];
    assign y4           = oy_q[3];
    assign frame_done   = done_q;
    assign quad_found   = found_q;
    assign marker_count = mcount_q;
endmodule
